ksa_shuffle_ctrl: RTL and testbench

- Sequences phase 2 of the RC4 key-scheduling algorithm on the 256x8 S memory, after S[i]=i initialisation has completed.
- For i = 0..255: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Owns the S-memory address, data and write-enable bus while busy. The top-level controller starts it and waits for done.

---
 rtl/ksa_shuffle_ctrl.sv | 127 ++++++++++++
 tb/tb_ksa_shuffle_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ksa_shuffle_ctrl.sv
// RC4 key-scheduling swap sequencer: walks i = 0..255 over the S memory, updating j and swapping S[i]/S[j].
// Optional macro KSA_SWAP_SKIP_EN: skip both writes when i == j (4-cycle iteration).
module ksa_shuffle_ctrl #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             mem_q,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_data,
    output logic                   mem_wren,
    output logic                   busy,
    output logic                   done
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_SI   = 3'd1;
    localparam logic [2:0] WAIT_SI = 3'd2;
    localparam logic [2:0] RD_SJ   = 3'd3;
    localparam logic [2:0] WAIT_SJ = 3'd4;
    localparam logic [2:0] WR_I    = 3'd5;
    localparam logic [2:0] WR_J    = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    logic [2:0]    state;
    logic [7:0]    i, j, si, sj;
    logic [KW-1:0] k;
    logic [7:0]    key_arr [KEY_BYTES];
    logic [7:0]    key_byte;

    // Byte 0 of the key sits in the most significant byte of secret_key.
    for (genvar b = 0; b < KEY_BYTES; b++) begin : g_key
        assign key_arr[b] = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
    assign key_byte = key_arr[k];

    // End-of-iteration decision, shared by WR_J and the optional i==j skip.
    logic [2:0]    adv_state;
    logic [7:0]    adv_i;
    logic [KW-1:0] adv_k;
    always_comb begin
        adv_state = RD_SI;
        adv_i     = i + 8'd1;
        adv_k     = (k == KW'(KEY_BYTES-1)) ? '0 : k + KW'(1);
        if (i == 8'hFF) begin
            adv_state = DONE;
            adv_i     = i;
            adv_k     = k;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            si    <= '0;
            sj    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i     <= '0;
                    j     <= '0;
                    k     <= '0;
                    state <= RD_SI;
                end
                RD_SI: state <= WAIT_SI;
                WAIT_SI: begin
                    si    <= mem_q;
                    j     <= j + mem_q + key_byte;
                    state <= RD_SJ;
                end
                RD_SJ: state <= WAIT_SJ;
                WAIT_SJ: begin
                    sj    <= mem_q;
`ifdef KSA_SWAP_SKIP_EN
                    if (i == j) begin
                        i     <= adv_i;
                        k     <= adv_k;
                        state <= adv_state;
                    end else begin
                        state <= WR_I;
                    end
`else
                    state <= WR_I;
`endif
                end
                WR_I: state <= WR_J;
                WR_J: begin
                    i     <= adv_i;
                    k     <= adv_k;
                    state <= adv_state;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state so reset clears them without a clock edge.
    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_wren = 1'b0;
        case (state)
            RD_SI: mem_addr = i;
            RD_SJ: mem_addr = j;
            WR_I: begin
                mem_addr = i;
                mem_data = sj;
                mem_wren = 1'b1;
            end
            WR_J: begin
                mem_addr = j;
                mem_data = si;
                mem_wren = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_ksa_shuffle_ctrl.sv
// Bench for ksa_shuffle_ctrl: shared S-memory model, RC4-KSA reference model feeding a write scoreboard.
module tb_ksa_shuffle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] key_r = '0;
    logic [7:0]  mem_q;
    logic        mem_init = 1'b0;

    logic [7:0] a3, d3, a4, d4;
    logic       w3, w4, b3, b4, dn3, dn4;
    logic [7:0] m_addr, m_data;
    logic       m_wren, m_busy, m_done;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ksa_shuffle_ctrl #(.KEY_BYTES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start & ~sel), .secret_key(key_r[23:0]),
        .mem_q(mem_q), .mem_addr(a3), .mem_data(d3), .mem_wren(w3), .busy(b3), .done(dn3));
    ksa_shuffle_ctrl #(.KEY_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start & sel), .secret_key(key_r),
        .mem_q(mem_q), .mem_addr(a4), .mem_data(d4), .mem_wren(w4), .busy(b4), .done(dn4));

    assign m_addr = sel ? a4 : a3;
    assign m_data = sel ? d4 : d3;
    assign m_wren = sel ? w4 : w3;
    assign m_busy = sel ? b4 : b3;
    assign m_done = sel ? dn4 : dn3;

    // Synchronous-read S memory, one cycle of read latency.
    logic [7:0] s_mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= 8'(n);
        end else if (m_wren) begin
            s_mem[m_addr] <= m_data;
        end
        mem_q <= s_mem[m_addr];
    end

    logic [15:0] exp_q [$];
    logic [7:0]  ref_s [256];

    always @(negedge clk) begin
        if (m_wren && !rst) begin
            logic [15:0] w;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%02h data=%02h, queue empty", m_addr, m_data);
            end else begin
                w = exp_q.pop_front();
                if (w != {m_addr, m_data}) begin
                    errors++;
                    $display("FAIL write: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             m_addr, m_data, w[15:8], w[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic build_model(input logic [31:0] key, input int nb, output int exp_busy);
        logic [7:0] j, t, kb;
        for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
        exp_q.delete();
        j = 0;
        exp_busy = 0;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(nb-1-(i % nb)) +: 8];
            j = j + ref_s[i] + kb;
`ifdef KSA_SWAP_SKIP_EN
            if (j == 8'(i)) begin
                exp_busy += 4;
                continue;
            end
`endif
            exp_busy += 6;
            exp_q.push_back({8'(i), ref_s[j]});
            exp_q.push_back({j, ref_s[i]});
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
        end
    endtask

    task automatic init_mem();
        @(negedge clk) mem_init = 1'b1;
        @(negedge clk) mem_init = 1'b0;
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] key;
        int          restart_at;
        int          exp_busy;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int busy_cnt, done_cyc, mb, exp_b, bad;
        sel   = v.sel;
        key_r = v.key;
        init_mem();
        build_model(v.key, v.sel ? 4 : 3, mb);
`ifdef KSA_SWAP_SKIP_EN
        exp_b = mb;
`else
        exp_b = v.exp_busy;
`endif
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cnt = 0;
        done_cyc = 0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (m_busy) busy_cnt++;
            if (m_done) begin
                done_cyc = cyc;
                break;
            end
            start = (cyc == v.restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", busy_cnt, exp_b);
        check("done_cycle", done_cyc, exp_b + 1);
        @(negedge clk);
        check("done_pulse_width", int'(m_done), 0);
        check("idle_after_done", int'(m_busy), 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== ref_s[n]) bad++;
        check("final_s_mismatches", bad, 0);
        check("writes_left", exp_q.size(), 0);
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{sel: 1'b0, key: 32'h0000_0249, restart_at: 0,   exp_busy: 1536};
        tbl[1] = '{sel: 1'b0, key: 32'h0000_0249, restart_at: 100, exp_busy: 1536};
        tbl[2] = '{sel: 1'b0, key: 32'h0000_0000, restart_at: 0,   exp_busy: 1536};
        tbl[3] = '{sel: 1'b1, key: 32'h0102_0304, restart_at: 0,   exp_busy: 1536};
        tbl[4] = '{sel: 1'b0, key: 32'h00FF_FFFF, restart_at: 0,   exp_busy: 1536};

        #3;
        check("rst_busy3", int'(b3), 0);
        check("rst_done3", int'(dn3), 0);
        check("rst_wren3", int'(w3), 0);
        check("rst_addr3", int'(a3), 0);
        check("rst_busy4", int'(b4), 0);
        check("rst_addr4", int'(a4), 0);
        @(negedge clk) rst = 1'b0;

        for (int t = 0; t < 5; t++) run_vec(tbl[t]);

        // Asynchronous reset in the middle of a run.
        sel   = 1'b0;
        key_r = 32'h0000_0249;
        init_mem();
        begin
            int mb;
            build_model(key_r, 3, mb);
        end
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (499) @(negedge clk);
        check("busy_before_rst", int'(m_busy), 1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_wren", int'(m_wren), 0);
        check("async_rst_busy", int'(m_busy), 0);
        check("async_rst_addr", int'(m_addr), 0);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        run_vec(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
